// File: rtl/logic_gate_pipe_if.sv
// Streaming handshake bundle for logic_gate_pipe: input beats and packet results.
// The out_parity signal is present only when LOGIC_GATE_PIPE_PARITY_EN is defined.
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [CNT_W-1:0] out_beats;
    logic             out_sat;
    logic             out_zero;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic             out_parity;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_y, out_beats, out_sat, out_zero, out_parity
    );
    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_beats, out_sat, out_zero, out_parity
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_y, out_beats, out_sat, out_zero
    );
    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_beats, out_sat, out_zero
    );
`endif
endinterface

// File: rtl/logic_gate_pipe.sv
// Registered bitwise logic op (AND/OR/XOR/PASS, optional invert) folding multi-beat packets.
// Optional feature macro: LOGIC_GATE_PIPE_PARITY_EN adds out_parity (XOR-reduction of out_y).
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             rst,
    logic_gate_pipe_if.slave bus
);
    typedef enum logic {IDLE, ACC} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             osat_q, osat_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic [2:0]       op_eff;
    logic [WIDTH-1:0] beat_v;
    logic [WIDTH-1:0] acc_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             sat_nx;
    logic [WIDTH-1:0] res;

    function automatic logic [WIDTH-1:0] base_op(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        case (op)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return x;
        endcase
    endfunction

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // The first beat of a packet uses its own op; later beats reuse the latched one.
    always_comb begin
        op_eff = (state_q == IDLE) ? bus.in_op : op_q;
        beat_v = base_op(op_eff[1:0], bus.in_a, bus.in_b);
        acc_nx = beat_v;
        cnt_nx = CNT_ONE;
        sat_nx = 1'b0;
        if (state_q == ACC) begin
            acc_nx = (op_q[1:0] == 2'd3) ? beat_v : base_op(op_q[1:0], acc_q, beat_v);
            if (cnt_q == CNT_MAX) begin
                cnt_nx = cnt_q;
                sat_nx = 1'b1;
            end else begin
                cnt_nx = cnt_q + CNT_ONE;
                sat_nx = sat_q;
            end
        end
        res = op_eff[2] ? ~acc_nx : acc_nx;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        valid_d = valid_q && !bus.out_ready;
        y_d     = y_q;
        beats_d = beats_q;
        osat_d  = osat_q;
        zero_d  = zero_q;
        if (accept) begin
            acc_d   = acc_nx;
            op_d    = op_eff;
            cnt_d   = cnt_nx;
            sat_d   = sat_nx;
            state_d = bus.in_last ? IDLE : ACC;
            if (bus.in_last) begin
                valid_d = 1'b1;
                y_d     = res;
                beats_d = cnt_nx;
                osat_d  = sat_nx;
                zero_d  = (res == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            y_q     <= '0;
            beats_q <= '0;
            osat_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            beats_q <= beats_d;
            osat_q  <= osat_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_y     = y_q;
    assign bus.out_beats = beats_q;
    assign bus.out_sat   = osat_q;
    assign bus.out_zero  = zero_q;

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (accept && bus.in_last) begin
            parity_q <= ^res;
        end
    end

    assign bus.out_parity = parity_q;
`endif
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe (WIDTH=8, CNT_W=4).
// Covers reset, op sweep, multi-beat folding, saturation, backpressure, zero and parity.
module tb_logic_gate_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic_gate_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();
    logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Presents one beat, waits (bounded) for in_ready, returns #1 after the accepting edge.
    task automatic drive_beat(input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input logic last);
        int waited = 0;
        bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_last = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (!bus.in_ready) begin
            n_fail++;
            $display("FAIL beat_accept_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++;
        if (bus.out_y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h want 00", bus.out_y); end
        n_checks++;
        if (bus.out_beats !== 4'd0) begin n_fail++; $display("FAIL reset_beats: got %0d want 0", bus.out_beats); end
        n_checks++;
        if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", bus.out_sat); end
        n_checks++;
        if (bus.out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", bus.out_zero); end
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        n_checks++;
        if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", bus.out_parity); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        $display("reset: out_valid=%b out_y=%h out_zero=%b", bus.out_valid, bus.out_y, bus.out_zero);
    endtask

    task automatic test_reset_mid_packet();
        drive_beat(8'hFF, 8'h0F, 3'd1, 1'b0);
        drive_beat(8'h11, 8'h22, 3'd1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_emit: out_valid=%b want 0", bus.out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_during: out_valid=%b want 0", bus.out_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after: out_valid=%b want 0", bus.out_valid); end
        drive_beat(8'hF0, 8'h3C, 3'd0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 8'h30 || bus.out_beats !== 4'd1)
            begin n_fail++; $display("FAIL midrst_result: valid=%b y=%h beats=%0d want 1/30/1", bus.out_valid, bus.out_y, bus.out_beats); end
        $display("reset_mid_packet: y=%h beats=%0d", bus.out_y, bus.out_beats);
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        logic [7:0] exp_tab [8] = '{8'h4A, 8'hDF, 8'h95, 8'hCA, 8'hB5, 8'h20, 8'h6A, 8'h35};
        for (int i = 0; i < 8; i++) begin
            drive_beat(8'hCA, 8'h5F, 3'(i), 1'b1);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_y !== exp_tab[i])
                begin n_fail++; $display("FAIL sweep_op%0d: valid=%b y=%h want 1/%h", i, bus.out_valid, bus.out_y, exp_tab[i]); end
            n_checks++;
            if (bus.out_zero !== 1'b0 || bus.out_beats !== 4'd1 || bus.out_sat !== 1'b0)
                begin n_fail++; $display("FAIL sweep_flags_op%0d: zero=%b beats=%0d sat=%b want 0/1/0", i, bus.out_zero, bus.out_beats, bus.out_sat); end
            $display("sweep op=%0d: y=%h", i, bus.out_y);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_drain: out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_xor_packet();
        drive_beat(8'h01, 8'h02, 3'd2, 1'b0);
        drive_beat(8'h04, 8'h08, 3'd0, 1'b0);
        drive_beat(8'h10, 8'h20, 3'd0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 8'h3F || bus.out_beats !== 4'd3)
            begin n_fail++; $display("FAIL xor_packet: valid=%b y=%h beats=%0d want 1/3f/3", bus.out_valid, bus.out_y, bus.out_beats); end
        $display("xor_packet: y=%h beats=%0d", bus.out_y, bus.out_beats);
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 19; i++) drive_beat(8'hFF, 8'hFF, 3'd0, 1'b0);
        drive_beat(8'hFF, 8'hFF, 3'd0, 1'b1);
        n_checks++;
        if (bus.out_beats !== 4'd15 || bus.out_sat !== 1'b1 || bus.out_y !== 8'hFF)
            begin n_fail++; $display("FAIL sat_packet: beats=%0d sat=%b y=%h want 15/1/ff", bus.out_beats, bus.out_sat, bus.out_y); end
        $display("saturation: y=%h beats=%0d sat=%b", bus.out_y, bus.out_beats, bus.out_sat);
        drive_beat(8'h81, 8'h01, 3'd0, 1'b1);
        n_checks++;
        if (bus.out_beats !== 4'd1 || bus.out_sat !== 1'b0 || bus.out_y !== 8'h01)
            begin n_fail++; $display("FAIL sat_next_packet: beats=%0d sat=%b y=%h want 1/0/01", bus.out_beats, bus.out_sat, bus.out_y); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        drive_beat(8'h0F, 8'hF0, 3'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_y !== 8'hFF || bus.in_ready !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold_c%0d: valid=%b y=%h in_ready=%b want 1/ff/0", i, bus.out_valid, bus.out_y, bus.in_ready); end
        end
        bus.in_a = 8'h3C; bus.in_b = 8'h0F; bus.in_op = 3'd0; bus.in_last = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: in_ready=%b want 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 8'h0C)
            begin n_fail++; $display("FAIL bp_next_result: valid=%b y=%h want 1/0c", bus.out_valid, bus.out_y); end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate: out_valid=%b want 0", bus.out_valid); end
        $display("back_to_back: second y=0c consumed");
    endtask

    task automatic test_zero_parity();
        drive_beat(8'hAA, 8'h55, 3'd0, 1'b1);
        n_checks++;
        if (bus.out_y !== 8'h00 || bus.out_zero !== 1'b1)
            begin n_fail++; $display("FAIL zero_result: y=%h zero=%b want 00/1", bus.out_y, bus.out_zero); end
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        n_checks++;
        if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_zero: got %b want 0", bus.out_parity); end
`endif
        drive_beat(8'h07, 8'h00, 3'd1, 1'b1);
        n_checks++;
        if (bus.out_y !== 8'h07 || bus.out_zero !== 1'b0)
            begin n_fail++; $display("FAIL nonzero_result: y=%h zero=%b want 07/0", bus.out_y, bus.out_zero); end
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        n_checks++;
        if (bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_odd: got %b want 1", bus.out_parity); end
`endif
        $display("zero_parity: y=%h zero=%b", bus.out_y, bus.out_zero);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_reset_mid_packet();
        test_sweep();
        test_xor_packet();
        test_saturation();
        test_back_to_back();
        test_zero_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
